// File: rtl/glb_arb_pkg.sv
// Shared types and constants for the GLB SRAM port arbiter and its
// round-robin building block.
package glb_arb_pkg;

  localparam logic [3:0] GLB_WEB_READ = 4'hF;
  localparam int         GLB_RD_LAT   = 1;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first unmasked requester at or after
// ptr, searching cyclically. Output is one-hot or zero.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     gnt
);

  logic [N-1:0] eligible;
  logic         found;
  int           idx;

  assign eligible = req & ~mask;

  // NOTE: every variable written here gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && eligible[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glb_port_arbiter.sv
// Shares the single-port GLB SRAM between NUM_REQ masters: round-robin with
// bounded lock bursts, zero-cycle grant, read data routed to the issuer.
module glb_port_arbiter
  import glb_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = GLB_RD_LAT,
  parameter int MAX_LOCK = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            lock_i,
  input  logic [NUM_REQ-1:0][3:0]       web_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic [3:0]                    glb_web_o,
  output logic [ADDR_W-1:0]             glb_addr_o,
  output logic [DATA_W-1:0]             glb_write_data_o,
  input  logic [DATA_W-1:0]             glb_read_data_i,
  output logic                          busy_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_e         state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   own_q;
  logic [CNT_W-1:0]   lock_cnt_q;
  logic [NUM_REQ-1:0] mask_q;
  logic [NUM_REQ-1:0] rd_pipe_q [RD_LAT];

  logic               owner_serve;
  logic [NUM_REQ-1:0] arb_mask;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   ptr_inc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               rd_beat;
  logic               rd_inflight;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req  (req_i),
    .ptr  (ptr_q),
    .mask (arb_mask),
    .gnt  (rr_gnt)
  );

  always_comb begin
    owner_serve = (state_q == LOCKED) && req_i[own_q];
    // The post-lock exclusion only applies in a true ARB cycle; a LOCKED
    // cycle whose owner dropped req arbitrates among everyone.
    arb_mask    = (state_q == ARB) ? mask_q : '0;

    gnt_o = '0;
    if (rst_n) gnt_o = owner_serve ? (NUM_REQ'(1) << own_q) : rr_gnt;

    gnt_idx          = '0;
    glb_web_o        = GLB_WEB_READ;
    glb_addr_o       = '0;
    glb_write_data_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_o[k]) begin
        gnt_idx          = PTR_W'(k);
        glb_web_o        = web_i[k];
        glb_addr_o       = addr_i[k];
        glb_write_data_o = wdata_i[k];
      end
    end

    ptr_inc = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    cnt_inc = lock_cnt_q + 1'b1;
    rd_beat = (|gnt_o) && (glb_web_o == GLB_WEB_READ);

    rd_inflight = 1'b0;
    for (int i = 0; i < RD_LAT; i++) rd_inflight = rd_inflight | (|rd_pipe_q[i]);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      own_q      <= '0;
      lock_cnt_q <= '0;
      mask_q     <= '0;
    end else begin
      mask_q <= '0;
      if (owner_serve) begin
        if (!lock_i[own_q]) begin
          state_q <= ARB;
        end else if (cnt_inc == CNT_W'(MAX_LOCK)) begin
          state_q    <= ARB;
          lock_cnt_q <= cnt_inc;
          mask_q     <= NUM_REQ'(1) << own_q;
        end else begin
          lock_cnt_q <= cnt_inc;
        end
      end else if (|gnt_o) begin
        ptr_q <= ptr_inc;
        if (lock_i[gnt_idx] && MAX_LOCK > 1) begin
          state_q    <= LOCKED;
          own_q      <= gnt_idx;
          lock_cnt_q <= CNT_W'(1);
        end else begin
          state_q <= ARB;
          // A one-beat lock budget is exhausted by the entry beat itself.
          if (lock_i[gnt_idx]) mask_q <= gnt_o;
        end
      end else begin
        state_q <= ARB;
      end
    end
  end

  // NOTE: this small pipeline is reset on purpose so reads in flight at
  // reset never surface as rvalid afterwards; wide data paths stay unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= '0;
    end else begin
      rd_pipe_q[0] <= rd_beat ? gnt_o : '0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign rvalid_o = rd_pipe_q[RD_LAT-1];
  assign rdata_o  = glb_read_data_i;
  assign busy_o   = (|gnt_o) || rd_inflight;

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Self-checking bench: SRAM model on the glb pins, plus a cycle-level
// reference model of arbitration, locking and read return.
module tb_glb_port_arbiter;
  import glb_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 1;
  localparam int ML = 64;

  logic                  clk;
  logic                  rst_n;
  logic [N-1:0]          req;
  logic [N-1:0]          lock;
  logic [N-1:0][3:0]     web;
  logic [N-1:0][AW-1:0]  addr;
  logic [N-1:0][DW-1:0]  wdata;
  logic [N-1:0]          gnt;
  logic [N-1:0]          rvalid;
  logic [DW-1:0]         rdata;
  logic [3:0]            glb_web;
  logic [AW-1:0]         glb_addr;
  logic [DW-1:0]         glb_wd;
  logic [DW-1:0]         glb_rd;
  logic                  busy;

  glb_port_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_LOCK(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .web_i(web),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .glb_web_o(glb_web), .glb_addr_o(glb_addr),
    .glb_write_data_o(glb_wd), .glb_read_data_i(glb_rd), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte-masked write, 1-cycle registered read.
  logic [31:0] sram [16384];
  logic [31:0] sram_rd;
  always @(posedge clk) begin
    if (glb_web != 4'hF) begin
      for (int b = 0; b < 4; b++)
        if (!glb_web[b]) sram[glb_addr[15:2]][8*b +: 8] = glb_wd[8*b +: 8];
    end else begin
      sram_rd <= sram[glb_addr[15:2]];
    end
  end
  assign glb_rd = sram_rd;

  // Reference model.
  typedef struct {int due; int m; logic [31:0] d;} rd_t;
  logic [31:0] ref_mem [16384];
  rd_t pend[$];
  int  m_ptr, m_owner, m_beats, m_excl, cyc;
  int  n_checks, n_errors;

  logic [N-1:0] exp_gnt, exp_rv, obs_gnt, obs_rv;
  logic [31:0]  exp_rd, obs_rd, exp_addr, obs_addr;
  logic [3:0]   exp_web, obs_web;
  logic         exp_busy, obs_busy;

  function automatic logic [31:0] pattern(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int model_pick();
    if (m_owner >= 0 && req[m_owner]) return m_owner;
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (req[k] && k != m_excl) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_beats = 0; m_excl = -1;
    pend.delete();
  endtask

  task automatic model_commit(int g);
    bit was_owner = (m_owner >= 0) && (g == m_owner);
    m_excl = -1;
    if (g < 0) begin
      m_owner = -1;
    end else if (was_owner) begin
      m_beats++;
      if (!lock[g]) m_owner = -1;
      else if (m_beats == ML) begin m_owner = -1; m_excl = g; end
    end else begin
      m_ptr = (g + 1) % N;
      if (lock[g]) begin m_owner = g; m_beats = 1; end
      else m_owner = -1;
    end
    if (g >= 0) begin
      if (web[g] == 4'hF) pend.push_back(rd_t'{cyc + RL, g, ref_mem[addr[g][15:2]]});
      else
        for (int b = 0; b < 4; b++)
          if (!web[g][b]) ref_mem[addr[g][15:2]][8*b +: 8] = wdata[g][8*b +: 8];
    end
  endtask

  // One clock: compute expectations, sample DUT at negedge, advance model.
  task automatic step();
    int g;
    @(negedge clk);
    g        = model_pick();
    exp_gnt  = (g >= 0) ? N'(1 << g) : '0;
    exp_web  = (g >= 0) ? web[g] : 4'hF;
    exp_addr = (g >= 0) ? addr[g] : '0;
    exp_rv   = '0;
    exp_rd   = '0;
    foreach (pend[i]) if (pend[i].due == cyc) begin exp_rv[pend[i].m] = 1'b1; exp_rd = pend[i].d; end
    exp_busy = (g >= 0) || (pend.size() > 0);
    obs_gnt = gnt; obs_rv = rvalid; obs_rd = rdata;
    obs_web = glb_web; obs_addr = glb_addr; obs_busy = busy;
    @(posedge clk);
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    model_commit(g);
    cyc++;
    #1;
  endtask

  task automatic set_idle();
    req = '0; lock = '0; web = {N{4'hF}}; addr = '0; wdata = '0;
  endtask

  task automatic set_read(int m, logic [31:0] a);
    req[m] = 1'b1; web[m] = 4'hF; addr[m] = a;
  endtask

  task automatic set_write(int m, logic [3:0] w, logic [31:0] a, logic [31:0] d);
    req[m] = 1'b1; web[m] = w; addr[m] = a; wdata[m] = d;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 1023)) << 2;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    for (int m = 0; m < N; m++) set_read(m, rand_addr());
    lock = '1;
    @(negedge clk);
    n_checks++; if (gnt !== '0)      begin n_errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    n_checks++; if (rvalid !== '0)   begin n_errors++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
    n_checks++; if (busy !== 1'b0)   begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (glb_web !== 4'hF) begin n_errors++; $display("FAIL reset_web got=%h exp=f", glb_web); end
    n_checks++; if (glb_addr !== '0 || glb_wd !== '0)
      begin n_errors++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", glb_addr, glb_wd); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    lock = '0;
  endtask

  task automatic test_rr_reads();
    for (int c = 0; c < 12; c++) begin
      for (int m = 0; m < N; m++) addr[m] = rand_addr();
      step();
      n_checks++; if (obs_gnt !== exp_gnt) begin n_errors++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, obs_gnt, exp_gnt); end
      if (c < 4) begin
        n_checks++; if (obs_gnt !== N'(1 << c)) begin n_errors++; $display("FAIL rr_order c=%0d got=%b exp=%b", c, obs_gnt, N'(1 << c)); end
      end
      n_checks++; if (obs_rv !== exp_rv) begin n_errors++; $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, obs_rv, exp_rv); end
      if (exp_rv != '0) begin
        n_checks++; if (obs_rd !== exp_rd) begin n_errors++; $display("FAIL rr_rdata c=%0d got=%h exp=%h", c, obs_rd, exp_rd); end
      end
    end
  endtask

  task automatic test_write_read();
    set_idle(); set_write(2, 4'h0, 32'h1000, 32'hDEADBEEF); step();
    n_checks++; if (obs_gnt !== 4'b0100) begin n_errors++; $display("FAIL wr_gnt got=%b exp=0100", obs_gnt); end
    set_idle(); set_read(0, 32'h1000); step();
    n_checks++; if (obs_gnt !== 4'b0001) begin n_errors++; $display("FAIL rd_gnt got=%b exp=0001", obs_gnt); end
    n_checks++; if (obs_rv !== exp_rv) begin n_errors++; $display("FAIL wr_no_rvalid got=%b exp=%b", obs_rv, exp_rv); end
    set_idle(); step();
    n_checks++; if (obs_rv !== 4'b0001 || obs_rd !== 32'hDEADBEEF)
      begin n_errors++; $display("FAIL wr_rd_data got=%b/%h exp=0001/deadbeef", obs_rv, obs_rd); end
    set_write(2, 4'hE, 32'h1000, 32'h11223344); step();
    set_idle(); set_read(0, 32'h1000); step();
    set_idle(); step();
    n_checks++; if (obs_rv !== 4'b0001 || obs_rd !== 32'hDEADBE44)
      begin n_errors++; $display("FAIL byte_wr_data got=%b/%h exp=0001/deadbe44", obs_rv, obs_rd); end
  endtask

  task automatic test_lock();
    logic [N-1:0] hist [70];
    int run;
    set_idle(); step();
    set_read(1, rand_addr()); lock[1] = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (c == 1) set_read(0, rand_addr());
      addr[1] = rand_addr();
      step();
      hist[c] = obs_gnt;
      n_checks++; if (obs_gnt !== exp_gnt) begin n_errors++; $display("FAIL lock_gnt c=%0d got=%b exp=%b", c, obs_gnt, exp_gnt); end
      n_checks++; if (obs_rv !== exp_rv || (exp_rv != '0 && obs_rd !== exp_rd))
        begin n_errors++; $display("FAIL lock_rdata c=%0d got=%b/%h exp=%b/%h", c, obs_rv, obs_rd, exp_rv, exp_rd); end
    end
    run = 0;
    while (run < 70 && hist[run] == 4'b0010) run++;
    n_checks++; if (run !== ML) begin n_errors++; $display("FAIL lock_burst_len got=%0d exp=%0d", run, ML); end
    n_checks++; if (hist[64] !== 4'b0001 || hist[65] !== 4'b0010)
      begin n_errors++; $display("FAIL lock_handoff got=%b,%b exp=0001,0010", hist[64], hist[65]); end
  endtask

  task automatic test_lock_drop();
    set_idle(); step();
    set_read(3, rand_addr()); lock[3] = 1'b1; step();
    n_checks++; if (obs_gnt !== 4'b1000) begin n_errors++; $display("FAIL drop_enter got=%b exp=1000", obs_gnt); end
    set_read(2, rand_addr()); step();
    n_checks++; if (obs_gnt !== 4'b1000) begin n_errors++; $display("FAIL drop_held got=%b exp=1000", obs_gnt); end
    req[3] = 1'b0; step();
    n_checks++; if (obs_gnt !== 4'b0100) begin n_errors++; $display("FAIL drop_same_cycle got=%b exp=0100", obs_gnt); end
    n_checks++; if (obs_gnt !== exp_gnt) begin n_errors++; $display("FAIL drop_model got=%b exp=%b", obs_gnt, exp_gnt); end
  endtask

  task automatic test_reset_midflight();
    set_idle();
    for (int m = 0; m < N; m++) set_read(m, rand_addr());
    step();
    n_checks++; if (obs_gnt === '0) begin n_errors++; $display("FAIL mid_pre_grant got=%b exp=nonzero", obs_gnt); end
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (rvalid !== '0 || gnt !== '0 || busy !== 1'b0)
      begin n_errors++; $display("FAIL mid_reset got=rv%b gnt%b busy%b exp=0", rvalid, gnt, busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    n_checks++; if (obs_gnt !== 4'b0001) begin n_errors++; $display("FAIL mid_first_grant got=%b exp=0001", obs_gnt); end
    n_checks++; if (obs_rv !== '0) begin n_errors++; $display("FAIL mid_stale_rvalid got=%b exp=0000", obs_rv); end
    step();
    n_checks++; if (obs_rv !== 4'b0001 || obs_rd !== exp_rd)
      begin n_errors++; $display("FAIL mid_post_read got=%b/%h exp=0001/%h", obs_rv, obs_rd, exp_rd); end
  endtask

  task automatic test_idle();
    set_idle(); step(); step();
    n_checks++; if (obs_web !== 4'hF || obs_addr !== '0)
      begin n_errors++; $display("FAIL idle_pins got=%h/%h exp=f/0", obs_web, obs_addr); end
    n_checks++; if (obs_busy !== 1'b0 || obs_gnt !== '0)
      begin n_errors++; $display("FAIL idle_busy got=%b/%b exp=0/0000", obs_busy, obs_gnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < N; m++) begin
        req[m]   = ($urandom_range(0, 3) != 0);
        lock[m]  = ($urandom_range(0, 3) == 0);
        web[m]   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        addr[m]  = rand_addr();
        wdata[m] = $urandom;
      end
      step();
      n_checks++; if (obs_gnt !== exp_gnt || (obs_gnt & ~req) !== '0)
        begin n_errors++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, obs_gnt, exp_gnt); end
      n_checks++; if (obs_rv !== exp_rv || (exp_rv != '0 && obs_rd !== exp_rd))
        begin n_errors++; $display("FAIL rand_rdata c=%0d got=%b/%h exp=%b/%h", c, obs_rv, obs_rd, exp_rv, exp_rd); end
      n_checks++; if (obs_web !== exp_web || obs_addr !== exp_addr || obs_busy !== exp_busy)
        begin n_errors++; $display("FAIL rand_pins c=%0d got=%h/%h/%b exp=%h/%h/%b", c, obs_web, obs_addr, obs_busy, exp_web, exp_addr, exp_busy); end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    for (int i = 0; i < 16384; i++) begin
      sram[i]    = pattern(i);
      ref_mem[i] = pattern(i);
    end
    model_reset();
    test_reset();
    test_rr_reads();
    test_write_read();
    test_lock();
    test_lock_drop();
    test_reset_midflight();
    test_idle();
    test_random();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
